// File: rtl/eco32f_pkg.sv
// Shared constants and types for the eco32f writeback path.
package eco32f_pkg;

  localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
  localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
  localparam logic [1:0] LSU_SIZE_WORD = 2'b10;

  localparam logic [0:0] WB_IDLE      = 1'b0;
  localparam logic [0:0] WB_LOAD_WAIT = 1'b1;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic        load;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  addr_lo;
    logic [31:0] alu;
  } wb_stage_t;

endpackage

// File: rtl/eco32f_load_align.sv
// Big-endian load lane select with sign/zero extension; purely combinational.
module eco32f_load_align
  import eco32f_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            size,
  input  logic                  sgn,
  input  logic [1:0]            addr_lo,
  output logic [DATA_WIDTH-1:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = data[31:24];
      2'd1:    lane_b = data[23:16];
      2'd2:    lane_b = data[15:8];
      default: lane_b = data[7:0];
    endcase
    lane_h = addr_lo[1] ? data[15:0] : data[31:16];

    case (size)
      LSU_SIZE_BYTE: result = {{24{sgn & lane_b[7]}}, lane_b};
      LSU_SIZE_HALF: result = {{16{sgn & lane_h[15]}}, lane_h};
      default:       result = data;
    endcase
  end

endmodule

// File: rtl/eco32f_writeback.sv
// Writeback stage: stage register, load-completion FSM and the single
// register-file write port.
//   state        | meaning
//   WB_IDLE      | no load outstanding; captured non-load writes this cycle
//   WB_LOAD_WAIT | captured load waiting for dbus_ack / dbus_err
module eco32f_writeback
  import eco32f_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_stall,
  input  logic                  mem_flush,
  input  logic [4:0]            mem_rf_r_addr,
  input  logic                  mem_rf_r_we,
  input  logic [DATA_WIDTH-1:0] mem_alu_result,
  input  logic                  mem_load,
  input  logic [1:0]            mem_lsu_size,
  input  logic                  mem_lsu_signed,
  input  logic [1:0]            mem_addr_lo,
  input  logic [DATA_WIDTH-1:0] dbus_dat_i,
  input  logic                  dbus_ack,
  input  logic                  dbus_err,
  output logic [4:0]            wb_rf_r_addr,
  output logic                  wb_rf_r_we,
  output logic [DATA_WIDTH-1:0] wb_rf_r,
  output logic                  wb_stall,
  output logic                  wb_bus_err
);

  wb_stage_t             stg;
  logic                  fresh;
  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] rf_hold;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  advance;
  logic                  load_done;
  logic                  we_raw;

  eco32f_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .data    (dbus_dat_i),
    .size    (stg.size),
    .sgn     (stg.sgn),
    .addr_lo (stg.addr_lo),
    .result  (load_data)
  );

  assign wb_stall   = (state == WB_LOAD_WAIT) & ~dbus_ack & ~dbus_err;
  assign wb_bus_err = (state == WB_LOAD_WAIT) & dbus_err;
  assign load_done  = (state == WB_LOAD_WAIT) & dbus_ack & ~dbus_err;
  // Nothing new enters while a load is outstanding, even if MEM is not stalled.
  assign advance    = ~mem_stall & ~wb_stall;

  always_comb begin
    we_raw = 1'b0;
    if (load_done)
      we_raw = stg.we;
    else if (state == WB_IDLE && fresh)
      we_raw = stg.we;
  end

  assign wb_rf_r_addr = stg.rd;
  assign wb_rf_r_we   = we_raw & (stg.rd != 5'd0);
  // The bypass register downstream relies on this holding between writes.
  assign wb_rf_r      = wb_rf_r_we ? ((state == WB_LOAD_WAIT) ? load_data : stg.alu)
                                   : rf_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg   <= '0;
      fresh <= 1'b0;
    end else begin
      fresh <= advance;
      if (advance) begin
        stg.rd      <= mem_rf_r_addr;
        stg.we      <= mem_rf_r_we & ~mem_flush;
        stg.load    <= mem_load & ~mem_flush;
        stg.size    <= mem_lsu_size;
        stg.sgn     <= mem_lsu_signed;
        stg.addr_lo <= mem_addr_lo;
        stg.alu     <= mem_alu_result;
      end
    end
  end

  // A load enters LOAD_WAIT at its capture edge so a zero-wait ack completes
  // in the very next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= WB_IDLE;
    else if (advance)
      state <= (mem_load & ~mem_flush) ? WB_LOAD_WAIT : WB_IDLE;
    else if (state == WB_LOAD_WAIT && (dbus_ack || dbus_err))
      state <= WB_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rf_hold <= '0;
    else if (wb_rf_r_we)
      rf_hold <= wb_rf_r;
  end

endmodule

// File: tb/tb_eco32f_writeback.sv
// Directed bench for eco32f_writeback with a transaction-level reference model.
module tb_eco32f_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_stall, mem_flush, mem_rf_r_we, mem_load, mem_lsu_signed;
  logic [4:0]  mem_rf_r_addr;
  logic [31:0] mem_alu_result, dbus_dat_i;
  logic [1:0]  mem_lsu_size, mem_addr_lo;
  logic        dbus_ack, dbus_err;
  logic [4:0]  wb_rf_r_addr;
  logic        wb_rf_r_we, wb_stall, wb_bus_err;
  logic [31:0] wb_rf_r;

  int checks = 0;
  int failures = 0;

  eco32f_writeback #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .mem_stall(mem_stall), .mem_flush(mem_flush),
    .mem_rf_r_addr(mem_rf_r_addr), .mem_rf_r_we(mem_rf_r_we),
    .mem_alu_result(mem_alu_result), .mem_load(mem_load),
    .mem_lsu_size(mem_lsu_size), .mem_lsu_signed(mem_lsu_signed),
    .mem_addr_lo(mem_addr_lo), .dbus_dat_i(dbus_dat_i), .dbus_ack(dbus_ack),
    .dbus_err(dbus_err), .wb_rf_r_addr(wb_rf_r_addr), .wb_rf_r_we(wb_rf_r_we),
    .wb_rf_r(wb_rf_r), .wb_stall(wb_stall), .wb_bus_err(wb_bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Shift the addressed lane down, mask to its width, then extend.
  function automatic logic [31:0] align_model(input logic [31:0] d, input logic [1:0] sz,
                                              input logic sg, input logic [1:0] lo);
    int sh, w;
    logic [31:0] v, m;
    if (sz == 2'b00) begin w = 8;  sh = (3 - int'(lo)) * 8; end
    else if (sz == 2'b01) begin w = 16; sh = lo[1] ? 0 : 16; end
    else begin w = 32; sh = 0; end
    v = d >> sh;
    if (w == 32) return v;
    m = (32'h1 << w) - 32'h1;
    v = v & m;
    if (sg && v[w-1]) v = v | ~m;
    return v;
  endfunction

  // Reference model: one captured instruction plus "load outstanding" flag.
  logic        m_pend, m_fresh, m_we, m_sg;
  logic [1:0]  m_sz, m_lo;
  logic [4:0]  m_addr;
  logic [31:0] m_alu, m_last;

  always @(negedge clk) begin
    logic exp_stall, exp_berr, wr, ld;
    logic [31:0] d;
    if (!rst) begin
      m_pend = 1'b0; m_fresh = 1'b0; m_last = '0; m_addr = '0; m_we = 1'b0;
      chk("rst_we", 32'(wb_rf_r_we), 32'd0);
      chk("rst_data", wb_rf_r, 32'd0);
      chk("rst_addr", 32'(wb_rf_r_addr), 32'd0);
      chk("rst_stall", 32'(wb_stall), 32'd0);
      chk("rst_berr", 32'(wb_bus_err), 32'd0);
    end else begin
      exp_stall = m_pend && !dbus_ack && !dbus_err;
      exp_berr  = m_pend && dbus_err;
      wr = 1'b0;
      d  = '0;
      if (m_pend) begin
        if (dbus_ack && !dbus_err) begin
          wr = m_we;
          d  = align_model(dbus_dat_i, m_sz, m_sg, m_lo);
        end
      end else if (m_fresh) begin
        wr = m_we;
        d  = m_alu;
      end
      if (m_addr == 5'd0) wr = 1'b0;
      chk("m_we", 32'(wb_rf_r_we), 32'(wr));
      chk("m_data", wb_rf_r, wr ? d : m_last);
      chk("m_addr", 32'(wb_rf_r_addr), 32'(m_addr));
      chk("m_stall", 32'(wb_stall), 32'(exp_stall));
      chk("m_berr", 32'(wb_bus_err), 32'(exp_berr));
      if (wr) m_last = d;
      if (!mem_stall && !exp_stall) begin
        ld      = mem_load && !mem_flush;
        m_we    = mem_rf_r_we && !mem_flush;
        m_sz    = mem_lsu_size;
        m_sg    = mem_lsu_signed;
        m_lo    = mem_addr_lo;
        m_alu   = mem_alu_result;
        m_addr  = mem_rf_r_addr;
        m_pend  = ld;
        m_fresh = !ld;
      end else begin
        m_fresh = 1'b0;
        if (!exp_stall) m_pend = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    mem_stall = 1'b0; mem_flush = 1'b0; mem_rf_r_we = 1'b0; mem_load = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic we, input logic [31:0] alu,
                       input logic ld, input logic [1:0] sz, input logic sg,
                       input logic [1:0] lo);
    mem_stall = 1'b0; mem_flush = 1'b0;
    mem_rf_r_addr = rd; mem_rf_r_we = we; mem_alu_result = alu;
    mem_load = ld; mem_lsu_size = sz; mem_lsu_signed = sg; mem_addr_lo = lo;
  endtask

  typedef struct {
    logic [31:0] dat;
    logic [1:0]  sz;
    logic        sg;
    logic [1:0]  lo;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t vecs[6] = '{
    '{32'h11A23344, 2'b00, 1'b0, 2'd3, 32'h00000044},
    '{32'h80017FFF, 2'b01, 1'b1, 2'd1, 32'hFFFF8001},
    '{32'h80017FFF, 2'b01, 1'b1, 2'd3, 32'h00007FFF},
    '{32'hCAFEF00D, 2'b10, 1'b1, 2'd0, 32'hCAFEF00D},
    '{32'h80FF0000, 2'b00, 1'b1, 2'd0, 32'hFFFFFF80},
    '{32'h80FF0000, 2'b00, 1'b0, 2'd1, 32'h000000FF}
  };

  initial begin
    int n;
    rst = 1'b0;
    bubble();
    mem_rf_r_addr = '0; mem_alu_result = '0; mem_lsu_size = '0;
    mem_lsu_signed = 1'b0; mem_addr_lo = '0;
    dbus_dat_i = '0; dbus_ack = 1'b0; dbus_err = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("reset_we", 32'(wb_rf_r_we), 32'd0);
    chk("reset_stall", 32'(wb_stall), 32'd0);
    tick();
    rst = 1'b1;

    // ALU write to r5
    issue(5'd5, 1'b1, 32'h12345678, 1'b0, 2'b10, 1'b0, 2'd0);
    tick(); bubble();
    @(negedge clk);
    chk("alu_we", 32'(wb_rf_r_we), 32'd1);
    chk("alu_data", wb_rf_r, 32'h12345678);
    chk("alu_addr", 32'(wb_rf_r_addr), 32'd5);
    tick();
    @(negedge clk);
    chk("alu_we_once", 32'(wb_rf_r_we), 32'd0);
    chk("alu_hold", wb_rf_r, 32'h12345678);

    // Signed byte load, three wait cycles
    issue(5'd7, 1'b1, 32'h0, 1'b1, 2'b00, 1'b1, 2'd1);
    dbus_dat_i = 32'h11A23344;
    tick(); bubble();
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (wb_stall) n++;
      tick();
    end
    dbus_ack = 1'b1;
    @(negedge clk);
    chk("sb_stall_cycles", 32'(n), 32'd3);
    chk("sb_stall_done", 32'(wb_stall), 32'd0);
    chk("sb_we", 32'(wb_rf_r_we), 32'd1);
    chk("sb_data", wb_rf_r, 32'hFFFFFFA2);
    tick(); dbus_ack = 1'b0;

    // Unsigned half load, zero-wait ack
    issue(5'd8, 1'b1, 32'h0, 1'b1, 2'b01, 1'b0, 2'd2);
    dbus_dat_i = 32'h00008001;
    tick(); bubble(); dbus_ack = 1'b1;
    @(negedge clk);
    chk("uh_stall", 32'(wb_stall), 32'd0);
    chk("uh_we", 32'(wb_rf_r_we), 32'd1);
    chk("uh_data", wb_rf_r, 32'h00008001);
    tick(); dbus_ack = 1'b0;

    // r0 is never written, by a load or by an ALU op
    issue(5'd0, 1'b1, 32'h0, 1'b1, 2'b10, 1'b0, 2'd0);
    dbus_dat_i = 32'hDEADBEEF;
    tick(); bubble(); dbus_ack = 1'b1;
    @(negedge clk);
    chk("r0_load_we", 32'(wb_rf_r_we), 32'd0);
    chk("r0_load_hold", wb_rf_r, 32'h00008001);
    tick(); dbus_ack = 1'b0;
    issue(5'd0, 1'b1, 32'h00000055, 1'b0, 2'b10, 1'b0, 2'd0);
    tick(); bubble();
    @(negedge clk);
    chk("r0_alu_we", 32'(wb_rf_r_we), 32'd0);
    tick();

    // Bus error (with ack also high) in LOAD_WAIT
    issue(5'd9, 1'b1, 32'h0, 1'b1, 2'b10, 1'b0, 2'd0);
    tick(); bubble();
    @(negedge clk);
    chk("err_wait_stall", 32'(wb_stall), 32'd1);
    tick(); dbus_err = 1'b1; dbus_ack = 1'b1;
    @(negedge clk);
    chk("err_pulse", 32'(wb_bus_err), 32'd1);
    chk("err_no_we", 32'(wb_rf_r_we), 32'd0);
    chk("err_stall", 32'(wb_stall), 32'd0);
    tick(); dbus_err = 1'b0; dbus_ack = 1'b0;
    @(negedge clk);
    chk("err_pulse_end", 32'(wb_bus_err), 32'd0);
    tick();

    // Reset in the middle of LOAD_WAIT, then a late ack
    issue(5'd11, 1'b1, 32'h0, 1'b1, 2'b00, 1'b1, 2'd0);
    tick(); bubble();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(wb_stall), 32'd0);
    chk("mid_rst_data", wb_rf_r, 32'd0);
    chk("mid_rst_addr", 32'(wb_rf_r_addr), 32'd0);
    tick(); rst = 1'b1; dbus_ack = 1'b1; dbus_dat_i = 32'hFF000000;
    @(negedge clk);
    chk("late_ack_we", 32'(wb_rf_r_we), 32'd0);
    chk("late_ack_data", wb_rf_r, 32'd0);
    tick(); dbus_ack = 1'b0;

    // Flushed load: no LOAD_WAIT, no write
    issue(5'd12, 1'b1, 32'h0, 1'b1, 2'b10, 1'b0, 2'd0);
    mem_flush = 1'b1;
    tick(); bubble();
    @(negedge clk);
    chk("flush_stall", 32'(wb_stall), 32'd0);
    tick(); dbus_ack = 1'b1;
    @(negedge clk);
    chk("flush_we", 32'(wb_rf_r_we), 32'd0);
    tick(); dbus_ack = 1'b0;

    // Alignment table, zero-wait acks
    foreach (vecs[i]) begin
      issue(5'(16 + i), 1'b1, 32'h0, 1'b1, vecs[i].sz, vecs[i].sg, vecs[i].lo);
      dbus_dat_i = vecs[i].dat;
      tick(); bubble(); dbus_ack = 1'b1;
      @(negedge clk);
      chk($sformatf("align_%0d", i), wb_rf_r, vecs[i].exp);
      tick(); dbus_ack = 1'b0;
    end

    // Non-load captured in the ack cycle writes in the next cycle
    issue(5'd13, 1'b1, 32'h0, 1'b1, 2'b10, 1'b0, 2'd0);
    dbus_dat_i = 32'h13579BDF;
    tick();
    issue(5'd14, 1'b1, 32'h0BADC0DE, 1'b0, 2'b10, 1'b0, 2'd0);
    dbus_ack = 1'b1;
    @(negedge clk);
    chk("b2b_load_data", wb_rf_r, 32'h13579BDF);
    chk("b2b_load_addr", 32'(wb_rf_r_addr), 32'd13);
    tick(); bubble(); dbus_ack = 1'b0;
    @(negedge clk);
    chk("b2b_alu_data", wb_rf_r, 32'h0BADC0DE);
    chk("b2b_alu_addr", 32'(wb_rf_r_addr), 32'd14);
    tick();

    // A held MEM stage must not repeat the write
    issue(5'd3, 1'b1, 32'h00000077, 1'b0, 2'b10, 1'b0, 2'd0);
    tick();
    mem_stall = 1'b1;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (wb_rf_r_we) n++;
      tick();
    end
    chk("stall_single_write", 32'(n), 32'd1);
    bubble();
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
